// File: rtl/btb_pkg.sv
// Shared types and geometry helpers for the N-way branch target buffer.
// Geometry is derived from the top-level parameters via constant functions.
package btb_pkg;

  localparam int MAX_WAYS = 64;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } flush_state_e;

  function automatic int calc_set_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int calc_tag_w(input int xlen, input int sets);
    return xlen - 2 - $clog2(sets);
  endfunction

  // Lowest set bit index; 0 when the vector is empty.
  function automatic int first_one(input logic [MAX_WAYS-1:0] v);
    int r;
    r = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/btb_way_sel.sv
// Way selection for one BTB set: hit way, first free way and
// round-robin victim.
module btb_way_sel
  import btb_pkg::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int WAY_W    = 1
) (
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [NUM_WAYS-1:0] match,
  input  logic [WAY_W-1:0]    rr_ptr,
  output logic                hit,
  output logic [WAY_W-1:0]    hit_way,
  output logic                has_free,
  output logic [WAY_W-1:0]    free_way,
  output logic [WAY_W-1:0]    victim_way
);

  logic [NUM_WAYS-1:0] hits;
  logic [NUM_WAYS-1:0] free;

  assign hits     = valid & match;
  assign free     = ~valid;
  assign hit      = |hits;
  assign has_free = |free;

  assign hit_way  = WAY_W'(first_one(MAX_WAYS'(hits)));
  assign free_way = WAY_W'(first_one(MAX_WAYS'(free)));

  // A single-way set has nowhere else to go.
  assign victim_way = (NUM_WAYS > 1) ? rr_ptr : '0;

endmodule

// File: rtl/btb_nway.sv
// N-way set-associative BTB: combinational lookup, registered
// install/update/invalidate, and a one-set-per-cycle flush engine.
module btb_nway
  import btb_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int XLEN     = 32,
  parameter int TGT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             lk_hit,
  output logic [TGT_W-1:0] lk_target,
  output logic             lk_branch,
  output logic             lk_jump,
  input  logic             wr_en,
  input  logic [XLEN-1:0]  wr_pc,
  input  logic [TGT_W-1:0] wr_target,
  input  logic             wr_branch,
  input  logic             inv_en,
  input  logic [XLEN-1:0]  inv_pc,
  input  logic             flush_req,
  output logic             flush_busy
);

  localparam int SET_W = calc_set_w(NUM_SETS);
  localparam int WAY_W = calc_way_w(NUM_WAYS);
  localparam int TAG_W = calc_tag_w(XLEN, NUM_SETS);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] target;
    logic             branch;
  } entry_t;

  entry_t           mem [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] rr_q [NUM_SETS];

  flush_state_e     state_q, state_d;
  logic [SET_W-1:0] fcnt_q, fcnt_d;

  logic [SET_W-1:0] lk_set, wr_set, inv_set;
  logic [TAG_W-1:0] lk_tag, wr_tag, inv_tag;

  logic unused_pc_lsb;

  assign lk_set  = lk_pc[SET_W+1:2];
  assign lk_tag  = lk_pc[XLEN-1:SET_W+2];
  assign wr_set  = wr_pc[SET_W+1:2];
  assign wr_tag  = wr_pc[XLEN-1:SET_W+2];
  assign inv_set = inv_pc[SET_W+1:2];
  assign inv_tag = inv_pc[XLEN-1:SET_W+2];

  assign unused_pc_lsb = ^{lk_pc[1:0], wr_pc[1:0], inv_pc[1:0]};

  logic [NUM_WAYS-1:0] lk_vhit, inv_vhit;
  logic [NUM_WAYS-1:0] wr_valid, wr_match;

  always_comb begin
    lk_vhit  = '0;
    inv_vhit = '0;
    wr_valid = '0;
    wr_match = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      lk_vhit[w]  = mem[lk_set][w].valid &&
                    (mem[lk_set][w].tag == lk_tag);
      inv_vhit[w] = mem[inv_set][w].valid &&
                    (mem[inv_set][w].tag == inv_tag);
      wr_valid[w] = mem[wr_set][w].valid;
      wr_match[w] = (mem[wr_set][w].tag == wr_tag);
    end
  end

  logic [WAY_W-1:0] lk_way;
  entry_t           lk_sel;

  assign lk_way    = WAY_W'(first_one(MAX_WAYS'(lk_vhit)));
  assign lk_sel    = mem[lk_set][lk_way];
  assign lk_hit    = (|lk_vhit) & ~flush_busy;
  assign lk_target = lk_hit ? lk_sel.target : '0;
  assign lk_branch = lk_hit & lk_sel.branch;
  assign lk_jump   = lk_hit & ~lk_sel.branch;

  logic             wr_hit, wr_has_free;
  logic [WAY_W-1:0] wr_hit_way, wr_free_way, wr_victim;
  logic [WAY_W-1:0] wr_way, rr_inc;
  logic             wr_repl, wr_do, same_line;
  logic             inv_do;
  logic [WAY_W-1:0] inv_way;

  btb_way_sel #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_W    (WAY_W)
  ) u_wr_sel (
    .valid      (wr_valid),
    .match      (wr_match),
    .rr_ptr     (rr_q[wr_set]),
    .hit        (wr_hit),
    .hit_way    (wr_hit_way),
    .has_free   (wr_has_free),
    .free_way   (wr_free_way),
    .victim_way (wr_victim)
  );

  assign wr_way  = wr_hit      ? wr_hit_way  :
                   wr_has_free ? wr_free_way : wr_victim;
  assign wr_repl = ~wr_hit & ~wr_has_free;
  assign rr_inc  = (NUM_WAYS > 1) ? rr_q[wr_set] + WAY_W'(1) : '0;

  // Invalidate of the very line being written wins outright.
  assign same_line = (wr_set == inv_set) && (wr_tag == inv_tag);
  assign wr_do     = wr_en & ~flush_busy & ~(inv_en & same_line);

  assign inv_way = WAY_W'(first_one(MAX_WAYS'(inv_vhit)));
  assign inv_do  = inv_en & ~flush_busy & (|inv_vhit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) mem[s][w] <= '0;
      end
    end else if (flush_busy) begin
      rr_q[fcnt_q] <= '0;
      for (int w = 0; w < NUM_WAYS; w++) mem[fcnt_q][w].valid <= 1'b0;
    end else begin
      if (inv_do) mem[inv_set][inv_way].valid <= 1'b0;
      if (wr_do) begin
        mem[wr_set][wr_way] <= '{valid:  1'b1,
                                 tag:    wr_tag,
                                 target: wr_target,
                                 branch: wr_branch};
        if (wr_repl) rr_q[wr_set] <= rr_inc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          state_d = ST_FLUSH;
          fcnt_d  = '0;
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == SET_W'(NUM_SETS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign flush_busy = (state_q == ST_FLUSH);

endmodule

// File: doc/btb_nway.md
Name: btb_nway

Overview:
Parametrised N-way set-associative branch target buffer for the fetch/decode pipeline.
- Combinational lookup: IF2 stage presents a PC and gets hit, target and kind in the same cycle.
- Fill/update: ID stage writes resolved branch/jump targets.
- Beyond the 2-way predecessor: update-in-place on tag match (no duplicate entries), per-set round-robin replacement for any way count, single-entry invalidate, and a multi-cycle sequential flush engine.

Parameters:
- NUM_SETS, 16, number of sets; power of two, ≥2; SET_W = log2(NUM_SETS).
- NUM_WAYS, 2, ways per set; power of two, ≥1; WAY_W = max(1, log2(NUM_WAYS)).
- XLEN, 32, PC width.
- TGT_W, 32, stored target width.
- TAG_W = XLEN-2-SET_W, derived, not overridable.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset: asynchronous, active-low.
- lk_pc, input, XLEN, IF2 lookup PC.
- lk_hit, output, 1, valid tag match in lk_pc's set.
- lk_target, output, TGT_W, target of the hitting way; 0 on miss.
- lk_branch, output, 1, hit and entry is a conditional branch.
- lk_jump, output, 1, hit and entry is a jump.
- wr_en, input, 1, install/update request.
- wr_pc, input, XLEN, PC of the resolved instruction.
- wr_target, input, TGT_W, resolved target.
- wr_branch, input, 1, 1 = branch, 0 = jump.
- inv_en, input, 1, invalidate request.
- inv_pc, input, XLEN, PC to invalidate.
- flush_req, input, 1, one-cycle pulse that starts a full flush.
- flush_busy, output, 1, flush in progress.

Behaviour:
- Indexing: set = pc[SET_W+1:2]; tag = pc[XLEN-1:SET_W+2]; pc[1:0] ignored.
- Entry fields: valid, tag, target, branch bit. Each set also holds an rr_ptr[WAY_W-1:0].
- Reset (async): all valid = 0, all rr_ptr = 0, FSM = IDLE, flush_busy = 0. Hence lk_hit/lk_branch/lk_jump = 0 and lk_target = 0. Tag and target storage may stay uninitialised.
- Lookup: purely combinational, zero latency.
  - Hit when any way has valid and a matching tag. Multiple hits cannot occur; if they do, the lowest-index way wins.
  - lk_branch = hit & branch; lk_jump = hit & ~branch; the two are mutually exclusive.
  - While flush_busy = 1, all lookup outputs are forced to miss.
- Write (registered; visible the cycle after the edge):
  - Tag match in the set: overwrite target and branch in place. Valid stays 1; rr_ptr is unchanged.
  - Else, any invalid way: fill the lowest-index invalid way. rr_ptr is unchanged.
  - Else: replace way rr_ptr, then rr_ptr ← rr_ptr+1 (mod NUM_WAYS).
- Invalidate: if inv_pc matches a valid way, clear that valid bit; otherwise no effect. rr_ptr is unchanged.
- Simultaneous wr_en and inv_en:
  - Same set and same tag: invalidate wins, the entry ends invalid.
  - Otherwise both take effect in the same cycle.
- Lookup and write to the same set in the same cycle: the lookup sees pre-write contents.
- Flush FSM, states IDLE and FLUSH, with counter fcnt[SET_W-1:0]:
  - IDLE → FLUSH on flush_req; fcnt ← 0.
  - In FLUSH, each cycle clears valid for all ways of set fcnt and resets its rr_ptr, then fcnt++.
  - FLUSH → IDLE after the cycle that processes fcnt = NUM_SETS-1.
  - flush_busy = (state == FLUSH), asserted for exactly NUM_SETS cycles, starting the cycle after the flush_req edge.
  - wr_en and inv_en are ignored while flush_busy = 1. A write in the same cycle as flush_req is performed, then erased by the flush.
  - flush_req while busy is ignored; the flush does not restart.
- Reset mid-flush: immediate return to IDLE with all entries invalid.
- NUM_WAYS = 1: rr_ptr is a constant 0; replacement always overwrites way 0.

Decomposition:
- Shared package btb_pkg: entry struct/typedef (valid, tag, target, branch), localparams SET_W / WAY_W / TAG_W as functions of the parameters, and FSM state encoding.
- One sub-module, btb_way_sel: combinational; takes per-way valid and tag-match vectors plus rr_ptr and returns the hit way, first-invalid way and victim way.
- Storage, rr_ptr array and flush FSM stay in the top level.

Test Plan:
- Reset, then lookup pc=0x40 → lk_hit=0, lk_target=0, flush_busy=0.
- Write pc=0x104, target=0x200, branch=1; next cycle lookup 0x104 → hit=1, target=0x200, lk_branch=1, lk_jump=0. Rewrite 0x104 with target=0x300, branch=0 → same way updated, target=0x300, lk_jump=1, no second entry in the set.
- Defaults (16 sets, 2 ways): write 0x004, 0x044, 0x084 (all set 1) → 0x004 evicted, 0x044 and 0x084 hit. Write 0x0C4 → 0x044 evicted (round-robin). Repeat with NUM_WAYS=4 and 5 conflicting PCs → the first-installed entry is evicted.
- Install 0x104, then inv_en with inv_pc=0x104 → miss next cycle. Same-cycle wr_en/inv_en on 0x108 → entry ends invalid.
- Fill 8 entries, pulse flush_req → flush_busy high exactly 16 cycles. Lookups miss and wr_en is ignored during the flush; all 8 entries miss afterwards. A second flush_req at busy cycle 5 does not extend the flush.
- Assert rst_n=0 at flush cycle 7 → flush_busy drops immediately; after release, all lookups miss and a new write/lookup works.
